// File: rtl/mithril_main.sv
`default_nettype none
// ============================================================================
//  Module      : mithril_main
//  Description : Single-cycle 8-bit accumulator core. Fetches one 16-bit
//                instruction per clock from an external combinational ROM,
//                with an accumulator, 16x8 register file, Z/C flags, PC and
//                a registered output port.
//  Revision    : 1.0  initial release
// ============================================================================
module mithril_main #(
    parameter int DATA_W = 8,
    parameter int PC_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    output logic [PC_W-1:0]   instr_addr,
    input  logic [15:0]       instr_data,
    output logic [DATA_W-1:0] out_port,
    output logic              out_valid,
    output logic [DATA_W-1:0] acc_dbg,
    output logic              halted
);

    localparam logic [3:0] c_op_nop   = 4'h0;
    localparam logic [3:0] c_op_ldi   = 4'h1;
    localparam logic [3:0] c_op_ld    = 4'h2;
    localparam logic [3:0] c_op_st    = 4'h3;
    localparam logic [3:0] c_op_add   = 4'h4;
    localparam logic [3:0] c_op_sub   = 4'h5;
    localparam logic [3:0] c_op_and   = 4'h6;
    localparam logic [3:0] c_op_or    = 4'h7;
    localparam logic [3:0] c_op_xor   = 4'h8;
    localparam logic [3:0] c_op_addi  = 4'h9;
    localparam logic [3:0] c_op_jmp   = 4'hA;
    localparam logic [3:0] c_op_jz    = 4'hB;
    localparam logic [3:0] c_op_jc    = 4'hC;
    localparam logic [3:0] c_op_out   = 4'hD;
    localparam logic [3:0] c_op_shift = 4'hE;
    localparam logic [3:0] c_op_halt  = 4'hF;

    localparam logic [PC_W-1:0] c_pc_one = PC_W'(1);

    // Architectural state
    logic [PC_W-1:0]   r_pc;
    logic [DATA_W-1:0] r_acc;
    logic              r_z;
    logic              r_c;
    logic [DATA_W-1:0] r_regs [16];
    logic [DATA_W-1:0] r_out_port;
    logic              r_out_valid;
    logic              r_halted;

    // Instruction fields and datapath
    logic [3:0]        w_op;
    logic [3:0]        w_r;
    logic [7:0]        w_imm;
    logic [DATA_W-1:0] w_imm_d;
    logic [PC_W-1:0]   w_target;
    logic [DATA_W-1:0] w_rval;
    logic [DATA_W:0]   w_add_r;
    logic [DATA_W:0]   w_sub_r;
    logic [DATA_W:0]   w_add_i;

    // Next-state controls
    logic [PC_W-1:0]   w_pc_next;
    logic [DATA_W-1:0] w_acc_next;
    logic              w_z_next;
    logic              w_c_next;
    logic              w_upd_z;
    logic              w_reg_we;
    logic              w_out_we;
    logic              w_halt;

    assign w_op     = instr_data[15:12];
    assign w_r      = instr_data[11:8];
    assign w_imm    = instr_data[7:0];
    assign w_imm_d  = DATA_W'(w_imm);
    assign w_target = PC_W'(w_imm);
    assign w_rval   = r_regs[w_r];

    // Extra top bit carries out the carry (add) or borrow (sub)
    assign w_add_r  = {1'b0, r_acc} + {1'b0, w_rval};
    assign w_sub_r  = {1'b0, r_acc} - {1'b0, w_rval};
    assign w_add_i  = {1'b0, r_acc} + {1'b0, w_imm_d};

    // Decode and execute the current instruction
    always_comb begin
        w_pc_next  = r_pc + c_pc_one;
        w_acc_next = r_acc;
        w_z_next   = r_z;
        w_c_next   = r_c;
        w_upd_z    = 1'b0;
        w_reg_we   = 1'b0;
        w_out_we   = 1'b0;
        w_halt     = 1'b0;
        case (w_op)
            c_op_nop: ;
            c_op_ldi: begin
                w_acc_next = w_imm_d;
                w_upd_z    = 1'b1;
            end
            c_op_ld: begin
                w_acc_next = w_rval;
                w_upd_z    = 1'b1;
            end
            c_op_st:   w_reg_we = 1'b1;
            c_op_add: begin
                {w_c_next, w_acc_next} = w_add_r;
                w_upd_z = 1'b1;
            end
            c_op_sub: begin
                {w_c_next, w_acc_next} = w_sub_r;
                w_upd_z = 1'b1;
            end
            c_op_and: begin
                w_acc_next = r_acc & w_rval;
                w_upd_z    = 1'b1;
            end
            c_op_or: begin
                w_acc_next = r_acc | w_rval;
                w_upd_z    = 1'b1;
            end
            c_op_xor: begin
                w_acc_next = r_acc ^ w_rval;
                w_upd_z    = 1'b1;
            end
            c_op_addi: begin
                {w_c_next, w_acc_next} = w_add_i;
                w_upd_z = 1'b1;
            end
            c_op_jmp:  w_pc_next = w_target;
            c_op_jz:   if (r_z) w_pc_next = w_target;
            c_op_jc:   if (r_c) w_pc_next = w_target;
            c_op_out:  w_out_we = 1'b1;
            c_op_shift: begin
                if (w_imm[0]) begin
                    w_c_next   = r_acc[0];
                    w_acc_next = {1'b0, r_acc[DATA_W-1:1]};
                end else begin
                    w_c_next   = r_acc[DATA_W-1];
                    w_acc_next = {r_acc[DATA_W-2:0], 1'b0};
                end
                w_upd_z = 1'b1;
            end
            c_op_halt: begin
                w_halt    = 1'b1;
                w_pc_next = r_pc;
            end
            default: ;
        endcase
        if (w_upd_z) begin
            w_z_next = (w_acc_next == '0);
        end
    end

    // Commit state; a halted core freezes everything until reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc        <= '0;
            r_acc       <= '0;
            r_z         <= 1'b0;
            r_c         <= 1'b0;
            r_out_port  <= '0;
            r_out_valid <= 1'b0;
            r_halted    <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                r_regs[i] <= '0;
            end
        end else if (!r_halted) begin
            r_pc        <= w_pc_next;
            r_acc       <= w_acc_next;
            r_z         <= w_z_next;
            r_c         <= w_c_next;
            r_out_valid <= w_out_we;
            r_halted    <= w_halt;
            if (w_reg_we) begin
                r_regs[w_r] <= r_acc;
            end
            if (w_out_we) begin
                r_out_port <= r_acc;
            end
        end else begin
            r_out_valid <= 1'b0;
        end
    end

    assign instr_addr = r_pc;
    assign out_port   = r_out_port;
    assign out_valid  = r_out_valid;
    assign acc_dbg    = r_acc;
    assign halted     = r_halted;

endmodule
`default_nettype wire

// File: tb/tb_mithril_main.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mithril_main
//  Description : Directed self-checking bench for the mithril_main core.
//                A behavioural ROM array feeds instructions combinationally.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mithril_main;

    logic        clk;
    logic        rst;
    logic [7:0]  instr_addr;
    logic [15:0] instr_data;
    logic [7:0]  out_port;
    logic        out_valid;
    logic [7:0]  acc_dbg;
    logic        halted;

    logic [15:0] rom [256];

    int tests_run;
    int tests_failed;

    mithril_main #(.DATA_W(8), .PC_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .instr_addr (instr_addr),
        .instr_data (instr_data),
        .out_port   (out_port),
        .out_valid  (out_valid),
        .acc_dbg    (acc_dbg),
        .halted     (halted)
    );

    assign instr_data = rom[instr_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] ins(input logic [3:0] op, input logic [3:0] r,
                                        input logic [7:0] imm);
        return {op, r, imm};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    // Reset asserted for two cycles in the middle of a running program
    task automatic test_reset();
        clear_rom();
        rom[0] = ins(4'h1, 4'h0, 8'd7);
        rom[1] = ins(4'hD, 4'h0, 8'd0);
        rom[2] = ins(4'hA, 4'h0, 8'd1);
        apply_reset();
        repeat (4) tick();
        tests_run++;
        if (out_valid !== 1'b1 || out_port !== 8'd7) begin
            tests_failed++;
            $display("FAIL reset_prerun: out_valid=%0b out_port=%0d, required 1/7", out_valid, out_port);
        end
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        tests_run++;
        if (instr_addr !== 8'd0 || acc_dbg !== 8'd0 || out_valid !== 1'b0 ||
            halted !== 1'b0 || out_port !== 8'd0) begin
            tests_failed++;
            $display("FAIL reset_state: pc=%0d acc=%0d ov=%0b halted=%0b out=%0d, required all 0",
                     instr_addr, acc_dbg, out_valid, halted, out_port);
        end
        tick();
        tests_run++;
        if (instr_addr !== 8'd1 || acc_dbg !== 8'd7) begin
            tests_failed++;
            $display("FAIL reset_resume: pc=%0d acc=%0d, required 1/7", instr_addr, acc_dbg);
        end
    endtask

    // ADD with carry-out, OUT, SUB with borrow; carry observed via JC
    task automatic test_arith();
        logic [7:0] e_pc  [11];
        logic [7:0] e_acc [11];
        logic       e_ov  [11];
        logic [7:0] e_out [11];
        e_pc  = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd8, 8'd9, 8'd10, 8'd12, 8'd13, 8'd13};
        e_acc = '{8'd200, 8'd200, 8'd100, 8'd44, 8'd44, 8'd44, 8'd44, 8'd100, 8'd100, 8'd100, 8'd100};
        e_ov  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        e_out = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd44, 8'd44, 8'd44, 8'd44, 8'd44, 8'd100, 8'd100};
        clear_rom();
        rom[0]  = ins(4'h1, 4'h0, 8'd200);
        rom[1]  = ins(4'h3, 4'h1, 8'd0);
        rom[2]  = ins(4'h1, 4'h0, 8'd100);
        rom[3]  = ins(4'h4, 4'h1, 8'd0);
        rom[4]  = ins(4'hD, 4'h0, 8'd0);
        rom[5]  = ins(4'hC, 4'h0, 8'd8);
        rom[6]  = ins(4'hF, 4'h0, 8'd0);
        rom[8]  = ins(4'hB, 4'h0, 8'd6);
        rom[9]  = ins(4'h5, 4'h1, 8'd0);
        rom[10] = ins(4'hC, 4'h0, 8'd12);
        rom[11] = ins(4'hF, 4'h0, 8'd0);
        rom[12] = ins(4'hD, 4'h0, 8'd0);
        rom[13] = ins(4'hF, 4'h0, 8'd0);
        apply_reset();
        for (int t = 0; t < 11; t++) begin
            tick();
            tests_run++;
            if (instr_addr !== e_pc[t] || acc_dbg !== e_acc[t] ||
                out_valid !== e_ov[t] || out_port !== e_out[t]) begin
                tests_failed++;
                $display("FAIL arith_t%0d: pc=%0d acc=%0d ov=%0b out=%0d, required pc=%0d acc=%0d ov=%0b out=%0d",
                         t + 1, instr_addr, acc_dbg, out_valid, out_port,
                         e_pc[t], e_acc[t], e_ov[t], e_out[t]);
            end
        end
        tests_run++;
        if (halted !== 1'b1) begin
            tests_failed++;
            $display("FAIL arith_halt: halted=%0b, required 1", halted);
        end
    endtask

    // ST/LD, AND/OR/XOR and back-to-back OUT keeping out_valid high
    task automatic test_back_to_back();
        logic [7:0] e_acc [15];
        logic       e_ov  [15];
        logic [7:0] e_out [15];
        e_acc = '{8'h5A, 8'h5A, 8'h5A, 8'h0F, 8'h0F, 8'h5A, 8'h0A, 8'h0A,
                  8'h0F, 8'h0F, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55};
        e_ov  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                  1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        e_out = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h0A,
                  8'h0A, 8'h0F, 8'h0F, 8'h55, 8'h55, 8'h55, 8'h55};
        clear_rom();
        rom[0]  = ins(4'h1, 4'h0, 8'h5A);
        rom[1]  = ins(4'h3, 4'h3, 8'h00);
        rom[2]  = ins(4'h2, 4'h3, 8'h00);
        rom[3]  = ins(4'h1, 4'h0, 8'h0F);
        rom[4]  = ins(4'h3, 4'h4, 8'h00);
        rom[5]  = ins(4'h2, 4'h3, 8'h00);
        rom[6]  = ins(4'h6, 4'h4, 8'h00);
        rom[7]  = ins(4'hD, 4'h0, 8'h00);
        rom[8]  = ins(4'h7, 4'h4, 8'h00);
        rom[9]  = ins(4'hD, 4'h0, 8'h00);
        rom[10] = ins(4'h8, 4'h3, 8'h00);
        rom[11] = ins(4'hD, 4'h0, 8'h00);
        rom[12] = ins(4'hD, 4'h0, 8'h00);
        rom[13] = ins(4'h0, 4'h0, 8'h00);
        rom[14] = ins(4'hF, 4'h0, 8'h00);
        apply_reset();
        for (int t = 0; t < 15; t++) begin
            tick();
            tests_run++;
            if (acc_dbg !== e_acc[t] || out_valid !== e_ov[t] || out_port !== e_out[t]) begin
                tests_failed++;
                $display("FAIL b2b_t%0d: acc=%0h ov=%0b out=%0h, required acc=%0h ov=%0b out=%0h",
                         t + 1, acc_dbg, out_valid, out_port, e_acc[t], e_ov[t], e_out[t]);
            end
        end
        tests_run++;
        if (halted !== 1'b1 || instr_addr !== 8'd14) begin
            tests_failed++;
            $display("FAIL b2b_halt: halted=%0b pc=%0d, required 1/14", halted, instr_addr);
        end
    endtask

    // Countdown loop: emits 3,2,1 then halts at address 7
    task automatic test_countdown();
        logic [7:0] e_vals [3];
        int n;
        e_vals = '{8'd3, 8'd2, 8'd1};
        n = 0;
        clear_rom();
        rom[0] = ins(4'h1, 4'h0, 8'd1);
        rom[1] = ins(4'h3, 4'h2, 8'd0);
        rom[2] = ins(4'h1, 4'h0, 8'd3);
        rom[3] = ins(4'hD, 4'h0, 8'd0);
        rom[4] = ins(4'h5, 4'h2, 8'd0);
        rom[5] = ins(4'hB, 4'h0, 8'd7);
        rom[6] = ins(4'hA, 4'h0, 8'd3);
        rom[7] = ins(4'hF, 4'h0, 8'd0);
        apply_reset();
        for (int k = 0; k < 60 && !halted; k++) begin
            tick();
            if (out_valid === 1'b1) begin
                if (n < 3) begin
                    tests_run++;
                    if (out_port !== e_vals[n]) begin
                        tests_failed++;
                        $display("FAIL countdown_out%0d: out=%0d, required %0d", n, out_port, e_vals[n]);
                    end
                end
                n++;
            end
        end
        tests_run++;
        if (halted !== 1'b1 || n != 3 || instr_addr !== 8'd7) begin
            tests_failed++;
            $display("FAIL countdown_end: halted=%0b outputs=%0d pc=%0d, required 1/3/7",
                     halted, n, instr_addr);
        end
        repeat (3) tick();
        tests_run++;
        if (instr_addr !== 8'd7) begin
            tests_failed++;
            $display("FAIL countdown_pc_frozen: pc=%0d, required 7", instr_addr);
        end
    endtask

    // Z/C behaviour observed through JZ/JC and SHIFT results
    task automatic test_flags();
        logic [7:0] e_pc  [16];
        logic [7:0] e_acc [16];
        e_pc  = '{8'd1, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd9, 8'd11,
                  8'd12, 8'd13, 8'd15, 8'd16, 8'd17, 8'd18, 8'd20, 8'd20};
        e_acc = '{8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00,
                  8'h81, 8'h40, 8'h40, 8'h80, 8'h80, 8'h00, 8'h00, 8'h00};
        clear_rom();
        rom[0]  = ins(4'h1, 4'h0, 8'd0);
        rom[1]  = ins(4'hB, 4'h0, 8'd3);
        rom[2]  = ins(4'hF, 4'h0, 8'd0);
        rom[3]  = ins(4'h9, 4'h0, 8'd255);
        rom[4]  = ins(4'hB, 4'h0, 8'd2);
        rom[5]  = ins(4'hC, 4'h0, 8'd2);
        rom[6]  = ins(4'h9, 4'h0, 8'd1);
        rom[7]  = ins(4'hC, 4'h0, 8'd9);
        rom[8]  = ins(4'hF, 4'h0, 8'd0);
        rom[9]  = ins(4'hB, 4'h0, 8'd11);
        rom[10] = ins(4'hF, 4'h0, 8'd0);
        rom[11] = ins(4'h1, 4'h0, 8'h81);
        rom[12] = ins(4'hE, 4'h0, 8'd1);
        rom[13] = ins(4'hC, 4'h0, 8'd15);
        rom[14] = ins(4'hF, 4'h0, 8'd0);
        rom[15] = ins(4'hE, 4'h0, 8'd0);
        rom[16] = ins(4'hC, 4'h0, 8'd14);
        rom[17] = ins(4'hE, 4'h0, 8'd0);
        rom[18] = ins(4'hB, 4'h0, 8'd20);
        rom[19] = ins(4'hF, 4'h0, 8'd0);
        rom[20] = ins(4'hF, 4'h0, 8'd0);
        apply_reset();
        for (int t = 0; t < 16; t++) begin
            tick();
            tests_run++;
            if (instr_addr !== e_pc[t] || acc_dbg !== e_acc[t]) begin
                tests_failed++;
                $display("FAIL flags_t%0d: pc=%0d acc=%0h, required pc=%0d acc=%0h",
                         t + 1, instr_addr, acc_dbg, e_pc[t], e_acc[t]);
            end
        end
        tests_run++;
        if (halted !== 1'b1) begin
            tests_failed++;
            $display("FAIL flags_halt: halted=%0b, required 1", halted);
        end
    endtask

    // PC wraps from 255 to 0 on straight-line NOPs
    task automatic test_pc_wrap();
        logic [7:0] e_pc [4];
        e_pc = '{8'd254, 8'd255, 8'd0, 8'd1};
        clear_rom();
        apply_reset();
        repeat (254) tick();
        for (int t = 0; t < 4; t++) begin
            tests_run++;
            if (instr_addr !== e_pc[t]) begin
                tests_failed++;
                $display("FAIL pc_wrap_%0d: pc=%0d, required %0d", t, instr_addr, e_pc[t]);
            end
            tick();
        end
    endtask

    // Halted core ignores arbitrary instructions until reset
    task automatic test_halt();
        clear_rom();
        rom[0] = ins(4'h1, 4'h0, 8'h33);
        rom[1] = ins(4'hD, 4'h0, 8'h00);
        rom[2] = ins(4'hF, 4'h0, 8'h00);
        apply_reset();
        repeat (3) tick();
        tests_run++;
        if (halted !== 1'b1 || instr_addr !== 8'd2 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL halt_entry: halted=%0b pc=%0d ov=%0b, required 1/2/0",
                     halted, instr_addr, out_valid);
        end
        for (int i = 0; i < 256; i++) rom[i] = 16'($urandom);
        for (int t = 0; t < 10; t++) begin
            tick();
            tests_run++;
            if (acc_dbg !== 8'h33 || instr_addr !== 8'd2 || out_port !== 8'h33 ||
                out_valid !== 1'b0 || halted !== 1'b1) begin
                tests_failed++;
                $display("FAIL halt_hold_t%0d: acc=%0h pc=%0d out=%0h ov=%0b halted=%0b, required 33/2/33/0/1",
                         t, acc_dbg, instr_addr, out_port, out_valid, halted);
            end
        end
        rst = 1'b1;
        repeat (2) tick();
        tests_run++;
        if (halted !== 1'b0 || instr_addr !== 8'd0 || acc_dbg !== 8'd0 || out_port !== 8'd0) begin
            tests_failed++;
            $display("FAIL halt_reset: halted=%0b pc=%0d acc=%0h out=%0h, required all 0",
                     halted, instr_addr, acc_dbg, out_port);
        end
        rst = 1'b0;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        clear_rom();
        test_reset();
        test_arith();
        test_back_to_back();
        test_countdown();
        test_flags();
        test_pc_wrap();
        test_halt();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
